// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if: bundles the N-channel request side and the single output side of mux_arb_n.
// slave is the arbiter's view; master is the view of the sources and sink that drive it.
interface mux_arb_n_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
);
    localparam int SEL_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [SEL_WIDTH-1:0]         out_ch;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel registered multiplexer with valid/ready handshake.
// One channel is granted per cycle and its word is captured, with its channel index,
// into a single output register. The default build arbitrates round-robin starting at
// the channel after the last winner.
// Build option: define MUX_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins,
// no rotating pointer; channel 0 can starve the others).
module mux_arb_n #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_arb_n_if.slave bus
);
    localparam int SEL_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0]  out_ch_q, out_ch_d;
    logic                  out_valid_q, out_valid_d;
    logic [SEL_WIDTH-1:0]  start_ptr;
    logic [NUM_CH-1:0]     grant;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic                  grant_any;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  space;
    logic                  xfer;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign start_ptr = '0;
`else
    localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(NUM_CH - 1);

    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;

    assign start_ptr = ptr_q;

    // Pointer moves to the channel after the winner, wrapping at NUM_CH-1; idle holds it
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // One-hot grant: first valid channel found searching upward from start_ptr, modulo NUM_CH
    always_comb begin
        int                   idx;
        logic [SEL_WIDTH-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(start_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            sel = SEL_WIDTH'(idx);
            if (!grant_any && bus.in_valid[sel]) begin
                grant_any  = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

    // Word offered by the granted channel
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                grant_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The output register can take a word when empty or draining this cycle
    assign space        = ~out_valid_q | bus.out_ready;
    assign xfer         = grant_any & space & rst_n;
    assign bus.in_ready = grant & {NUM_CH{space & rst_n}};

    // Output register next state: load on transfer, clear valid on a pure drain, else hold
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register; reset discards any held word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: directed, table-driven bench for mux_arb_n (round-robin build, 4 x 32-bit).
// Each vector is applied after a falling edge; in_ready is checked before the next rising
// edge and the registered outputs 1 time unit after it.
module tb_mux_arb_n;
    localparam int DW  = 32;
    localparam int NCH = 4;

    localparam logic [127:0] DEF = {32'h3C3C3C3C, 32'h2B2B2B2B, 32'h1A1A1A1A, 32'h0F0F0F0F};

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_arb_n_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

    mux_arb_n #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string        name;
        logic         rst_n;
        logic [3:0]   vld;
        logic [127:0] data;
        logic         ordy;
        logic [3:0]   exp_rdy;
        logic         exp_ov;
        logic [31:0]  exp_od;
        logic [1:0]   exp_ch;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [127:0] dw(input int ch, input logic [31:0] val);
        logic [127:0] r;
        r = DEF;
        r[ch*32 +: 32] = val;
        return r;
    endfunction

    task automatic add(input string name, input logic rn, input logic [3:0] vld,
                       input logic [127:0] data, input logic ordy, input logic [3:0] rdy,
                       input logic ov, input logic [31:0] od, input logic [1:0] ch);
        vec_t v;
        v.name = name; v.rst_n = rn; v.vld = vld; v.data = data; v.ordy = ordy;
        v.exp_rdy = rdy; v.exp_ov = ov; v.exp_od = od; v.exp_ch = ch;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic [3:0] vld, input logic [127:0] data,
                         input logic ordy);
        @(negedge clk);
        rst_n         = rn;
        bus.in_valid  = vld;
        bus.in_data   = data;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic check_out(input string name, input logic ov, input logic [31:0] od,
                             input logic [1:0] ch);
        check({name, " out_valid"}, 32'(bus.out_valid), 32'(ov));
        check({name, " out_data"}, bus.out_data, od);
        check({name, " out_ch"}, 32'(bus.out_ch), 32'(ch));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        //   name        rst  vld      data                      ordy rdy      ov    data          ch
        add("reset",     0, 4'b1111, DEF,                      1, 4'b0000, 1'b0, 32'h00000000, 2'd0);
        add("rr0",       1, 4'b1111, DEF,                      1, 4'b0001, 1'b1, 32'h0F0F0F0F, 2'd0);
        add("rr1",       1, 4'b1111, DEF,                      1, 4'b0010, 1'b1, 32'h1A1A1A1A, 2'd1);
        add("rr2",       1, 4'b1111, DEF,                      1, 4'b0100, 1'b1, 32'h2B2B2B2B, 2'd2);
        add("rr3",       1, 4'b1111, DEF,                      1, 4'b1000, 1'b1, 32'h3C3C3C3C, 2'd3);
        add("rr4",       1, 4'b1111, DEF,                      1, 4'b0001, 1'b1, 32'h0F0F0F0F, 2'd0);
        add("rr5",       1, 4'b1111, DEF,                      1, 4'b0010, 1'b1, 32'h1A1A1A1A, 2'd1);
        for (int i = 0; i < 5; i++)
            add($sformatf("idle%0d", i), 1, 4'b0000, DEF,      1, 4'b0000, 1'b0, 32'h1A1A1A1A, 2'd1);
        add("bp_load",   1, 4'b0010, dw(1, 32'h12345678),      0, 4'b0010, 1'b1, 32'h12345678, 2'd1);
        for (int i = 0; i < 3; i++)
            add($sformatf("bp_stall%0d", i), 1, 4'b0100, DEF,  0, 4'b0000, 1'b1, 32'h12345678, 2'd1);
        add("bp_drain",  1, 4'b0100, DEF,                      1, 4'b0100, 1'b1, 32'h2B2B2B2B, 2'd2);
        add("wrap0",     1, 4'b0011, DEF,                      1, 4'b0001, 1'b1, 32'h0F0F0F0F, 2'd0);
        add("wrap1",     1, 4'b0011, DEF,                      1, 4'b0010, 1'b1, 32'h1A1A1A1A, 2'd1);
        add("drain_ld",  1, 4'b1000, dw(3, 32'hDEADBEEF),      1, 4'b1000, 1'b1, 32'hDEADBEEF, 2'd3);
        add("drain",     1, 4'b0000, DEF,                      1, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd3);

        foreach (vecs[n]) begin
            drive(vecs[n].rst_n, vecs[n].vld, vecs[n].data, vecs[n].ordy);
            check({vecs[n].name, " in_ready"}, 32'(bus.in_ready), 32'(vecs[n].exp_rdy));
            @(posedge clk);
            #1;
            check_out(vecs[n].name, vecs[n].exp_ov, vecs[n].exp_od, vecs[n].exp_ch);
        end

        // Reset mid-stall: load A5A5A5A5 from ch2 (pointer then 3) and stall it
        drive(1'b1, 4'b0100, dw(2, 32'hA5A5A5A5), 1'b0);
        check("rs_load in_ready", 32'(bus.in_ready), 32'h4);
        @(posedge clk); #1;
        check_out("rs_load", 1'b1, 32'hA5A5A5A5, 2'd2);

        drive(1'b1, 4'b0000, DEF, 1'b0);
        @(posedge clk); #1;
        check_out("rs_hold", 1'b1, 32'hA5A5A5A5, 2'd2);

        drive(1'b0, 4'b1111, DEF, 1'b0);
        check("rs_assert in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk); #1;
        check_out("rs_assert", 1'b0, 32'h00000000, 2'd0);

        // Pointer must restart at ch0 rather than ch3
        drive(1'b1, 4'b1111, DEF, 1'b1);
        check("rs_restart in_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk); #1;
        check_out("rs_restart", 1'b1, 32'h0F0F0F0F, 2'd0);
        check("rs_next in_ready", 32'(bus.in_ready), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
